// File: rtl/ps2_key_tx.sv
// Turns hps_io keyboard event words into device-side PS/2 clock/data frames.
// Events expand to E0/F0/code bytes, queue in a small FIFO, and shift out as 11-bit frames.
module ps2_key_tx #(
  parameter int CLK_HALF   = 1000,
  parameter int GAP        = 2000,
  parameter int FIFO_DEPTH = 8
) (
  input  logic        clk_sys,
  input  logic        I_RESET,
  input  logic [10:0] ps2_key,
  output logic        ps2_clk,
  output logic        ps2_data,
  output logic        busy,
  output logic        overflow
);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int CMAX = (CLK_HALF > GAP) ? CLK_HALF : GAP;
  localparam int CW   = $clog2(CMAX + 1);

  typedef enum logic [1:0] {S_IDLE, S_HIGH, S_LOW, S_GAP} state_t;

  logic armed, prev_toggle, evt;
  logic       pend_vld;
  logic [9:0] pend_word;
  logic [1:0] exp_cnt;
  logic [7:0] exp_b1, exp_b2;

  logic [7:0]  mem [FIFO_DEPTH];
  logic [AW:0] wptr, rptr, used, free_slots;
  logic        fifo_empty, pop;
  logic [7:0]  head;

  logic       from_pend, from_new, acc_try, acc_ok, to_pend, drop_pend;
  logic [9:0] acc_word;
  logic [1:0] acc_n;
  logic [7:0] s0, s1, s2;
  logic       wr_en;
  logic [7:0] wr_data;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [3:0]    bit_idx;
  logic [10:0]   frame;

  // The toggle bit is compared only after one armed cycle, so a level held through reset is not an event.
  assign evt = armed && (ps2_key[10] != prev_toggle);

  assign used       = wptr - rptr;
  assign free_slots = (AW+1)'(FIFO_DEPTH) - used;
  assign fifo_empty = (wptr == rptr);
  assign head       = mem[rptr[AW-1:0]];
  assign pop        = (state == S_IDLE) && !fifo_empty;

  // Acceptance: the first byte is written on the accepting edge, the rest follow one per cycle.
  always_comb begin
    from_pend = (exp_cnt == 2'd0) && pend_vld;
    from_new  = (exp_cnt == 2'd0) && !pend_vld && evt;
    acc_try   = from_pend || from_new;
    acc_word  = from_pend ? pend_word : ps2_key[9:0];
    acc_n     = 2'd1 + {1'b0, acc_word[8]} + {1'b0, ~acc_word[9]};
    acc_ok    = acc_try && (free_slots >= (AW+1)'(acc_n));
    to_pend   = evt && !from_new && (!pend_vld || from_pend);
    drop_pend = evt && !from_new && !to_pend;
    s0 = acc_word[7:0];
    s1 = 8'h00;
    s2 = 8'h00;
    case ({acc_word[8], acc_word[9]})
      2'b00: begin s0 = 8'hF0; s1 = acc_word[7:0]; end
      2'b10: begin s0 = 8'hE0; s1 = 8'hF0; s2 = acc_word[7:0]; end
      2'b11: begin s0 = 8'hE0; s1 = acc_word[7:0]; end
      default: ;
    endcase
    wr_en   = acc_ok || (exp_cnt != 2'd0);
    wr_data = (exp_cnt != 2'd0) ? exp_b1 : s0;
  end

  always_ff @(posedge clk_sys or negedge I_RESET) begin
    if (!I_RESET) begin
      armed       <= 1'b0;
      prev_toggle <= 1'b0;
      pend_vld    <= 1'b0;
      pend_word   <= '0;
      exp_cnt     <= 2'd0;
      exp_b1      <= 8'h00;
      exp_b2      <= 8'h00;
      overflow    <= 1'b0;
    end else begin
      overflow <= (acc_try && !acc_ok) || drop_pend;
      if (!armed) begin
        armed       <= 1'b1;
        prev_toggle <= ps2_key[10];
      end else if (evt) begin
        prev_toggle <= ps2_key[10];
      end
      if (to_pend) begin
        pend_vld  <= 1'b1;
        pend_word <= ps2_key[9:0];
      end else if (from_pend) begin
        pend_vld <= 1'b0;
      end
      if (exp_cnt != 2'd0) begin
        exp_b1  <= exp_b2;
        exp_cnt <= exp_cnt - 2'd1;
      end else if (acc_ok) begin
        exp_b1  <= s1;
        exp_b2  <= s2;
        exp_cnt <= acc_n - 2'd1;
      end
    end
  end

  always_ff @(posedge clk_sys) begin
    if (wr_en) mem[wptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk_sys or negedge I_RESET) begin
    if (!I_RESET) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      wptr <= wptr + (AW+1)'(wr_en);
      rptr <= rptr + (AW+1)'(pop);
    end
  end

  // Data only moves on HIGH entry; the consumer samples on the falling clock mid-bit.
  always_ff @(posedge clk_sys or negedge I_RESET) begin
    if (!I_RESET) begin
      state    <= S_IDLE;
      cnt      <= '0;
      bit_idx  <= 4'd0;
      frame    <= '1;
      ps2_clk  <= 1'b1;
      ps2_data <= 1'b1;
      busy     <= 1'b0;
    end else begin
      busy <= (state != S_IDLE) || !fifo_empty;
      case (state)
        S_IDLE: if (!fifo_empty) begin
          frame    <= {1'b1, ~^head, head, 1'b0};
          bit_idx  <= 4'd0;
          cnt      <= CW'(CLK_HALF - 1);
          ps2_clk  <= 1'b1;
          ps2_data <= 1'b0;
          state    <= S_HIGH;
        end
        S_HIGH: if (cnt == '0) begin
          ps2_clk <= 1'b0;
          cnt     <= CW'(CLK_HALF - 1);
          state   <= S_LOW;
        end else begin
          cnt <= cnt - CW'(1);
        end
        S_LOW: if (cnt == '0) begin
          ps2_clk <= 1'b1;
          if (bit_idx == 4'd10) begin
            ps2_data <= 1'b1;
            cnt      <= CW'(GAP - 1);
            state    <= S_GAP;
          end else begin
            bit_idx  <= bit_idx + 4'd1;
            ps2_data <= frame[bit_idx + 4'd1];
            cnt      <= CW'(CLK_HALF - 1);
            state    <= S_HIGH;
          end
        end else begin
          cnt <= cnt - CW'(1);
        end
        S_GAP: if (cnt == '0) state <= S_IDLE;
               else cnt <= cnt - CW'(1);
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_ps2_key_tx.sv
// Directed bench for ps2_key_tx: a wire monitor decodes frames and checks them against a byte scoreboard.
module tb_ps2_key_tx;
  localparam int CLK_HALF = 4, GAP = 8, FIFO_DEPTH = 8;

  logic        clk_sys = 1'b0;
  logic        I_RESET = 1'b0;
  logic [10:0] ps2_key = '0;
  logic        ps2_clk, ps2_data, busy, overflow;

  ps2_key_tx #(.CLK_HALF(CLK_HALF), .GAP(GAP), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk_sys(clk_sys), .I_RESET(I_RESET), .ps2_key(ps2_key),
    .ps2_clk(ps2_clk), .ps2_data(ps2_data), .busy(busy), .overflow(overflow)
  );

  always #5 clk_sys = ~clk_sys;

  int n_cmp = 0, n_fail = 0;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [7:0]  exp_q[$];
  logic [7:0]  rx_q[$];
  logic [23:0] sent_q[$];
  int          sent_n[$];
  int          idle_q[$];
  bit          collect = 1'b0;
  int          n_frames = 0, ovf_cnt = 0;
  logic [10:0] shreg = '0, last_frame = '0;
  int          bitn = 0, hi_cnt = 0, lo_cnt = 0, idle_cnt = 0;
  bit          in_frame = 1'b0;
  logic        pclk = 1'b1;

  always @(negedge clk_sys) if (overflow) ovf_cnt++;

  // Wire monitor: decodes frames, checks half-period lengths and framing, feeds the scoreboard.
  always @(negedge clk_sys) begin
    if (!I_RESET) begin
      bitn = 0; in_frame = 1'b0; idle_cnt = 0; pclk = 1'b1;
    end else begin
      if (!in_frame) begin
        if (ps2_clk && !ps2_data) begin
          in_frame = 1'b1; idle_q.push_back(idle_cnt); hi_cnt = 1; bitn = 0;
        end else if (ps2_clk && ps2_data) idle_cnt++;
      end else if (pclk && !ps2_clk) begin
        chk("hi_len", hi_cnt, CLK_HALF);
        shreg[bitn] = ps2_data; bitn++; lo_cnt = 1;
      end else if (!pclk && ps2_clk) begin
        chk("lo_len", lo_cnt, CLK_HALF);
        hi_cnt = 1;
        if (bitn == 11) begin
          chk("start", shreg[0], 0);
          chk("stop", shreg[10], 1);
          chk("parity", shreg[9], ~^shreg[8:1]);
          last_frame = shreg; n_frames++;
          in_frame = 1'b0; bitn = 0; idle_cnt = 1;
          if (collect) rx_q.push_back(shreg[8:1]);
          else if (exp_q.size() == 0) chk("sb_underrun", exp_q.size(), 1);
          else chk("byte", shreg[8:1], exp_q.pop_front());
        end
      end else if (ps2_clk) hi_cnt++;
      else lo_cnt++;
      pclk = ps2_clk;
    end
  end

  task automatic send(input bit pressed, input bit ext, input logic [7:0] code);
    logic [7:0]  b[$];
    logic [23:0] ev;
    ps2_key = {~ps2_key[10], pressed, ext, code};
    if (ext) b.push_back(8'hE0);
    if (!pressed) b.push_back(8'hF0);
    b.push_back(code);
    ev = '0;
    for (int i = 0; i < b.size(); i++) ev[8*i +: 8] = b[i];
    if (collect) begin sent_q.push_back(ev); sent_n.push_back(b.size()); end
    else foreach (b[i]) exp_q.push_back(b[i]);
    @(negedge clk_sys);
  endtask

  task automatic wait_idle(input int budget);
    int k = 0;
    repeat (4) @(negedge clk_sys);
    while ((busy || in_frame) && k < budget) begin @(negedge clk_sys); k++; end
    chk("idle_timeout", int'(k < budget), 1);
    repeat (2) @(negedge clk_sys);
  endtask

  // Each sent event must appear whole and in order, or be absent with one overflow pulse for it.
  task automatic walk(input string tag, input int ovf0);
    int p = 0, drops = 0;
    bit m;
    logic [23:0] ev;
    for (int i = 0; i < sent_q.size(); i++) begin
      ev = sent_q[i];
      m = (p + sent_n[i] <= rx_q.size());
      for (int j = 0; j < sent_n[i] && m; j++) if (rx_q[p+j] !== ev[8*j +: 8]) m = 1'b0;
      if (m) p += sent_n[i]; else drops++;
    end
    chk({tag, "_rx_used"}, p, rx_q.size());
    chk({tag, "_drops"}, drops, ovf_cnt - ovf0);
    sent_q.delete(); sent_n.delete(); rx_q.delete();
  endtask

  initial begin
    int o0, f0, k;
    repeat (3) @(negedge clk_sys);
    chk("rst_clk", ps2_clk, 1);
    chk("rst_data", ps2_data, 1);
    chk("rst_busy", busy, 0);
    chk("rst_ovf", overflow, 0);
    I_RESET = 1'b1;
    repeat (3) @(negedge clk_sys);

    // Make 0x1C.
    send(1'b1, 1'b0, 8'h1C);
    wait_idle(3000);
    chk("t1_frame", last_frame, 11'h438);
    chk("t1_busy", busy, 0);
    chk("t1_sb", exp_q.size(), 0);

    // Extended break 0x75: E0 F0 75 back to back.
    idle_q.delete();
    send(1'b0, 1'b1, 8'h75);
    wait_idle(3000);
    chk("t2_frames", idle_q.size(), 3);
    if (idle_q.size() == 3) begin
      chk("t2_gap1", idle_q[1], GAP + 1);
      chk("t2_gap2", idle_q[2], GAP + 1);
    end
    chk("t2_sb", exp_q.size(), 0);

    // Three 3-byte events on consecutive cycles: second waits in the pending slot, third is dropped.
    collect = 1'b1; o0 = ovf_cnt;
    send(1'b0, 1'b1, 8'h21);
    send(1'b0, 1'b1, 8'h22);
    send(1'b0, 1'b1, 8'h23);
    wait_idle(5000);
    chk("t3_ovf", ovf_cnt - o0, 1);
    walk("t3", o0);

    // Burst of five 2-byte releases, two cycles apart.
    o0 = ovf_cnt;
    for (int i = 0; i < 5; i++) begin
      send(1'b0, 1'b0, 8'h30 + 8'(i));
      @(negedge clk_sys);
    end
    wait_idle(5000);
    collect = 1'b0;
    chk("t4_ovf_seen", int'(ovf_cnt - o0 >= 1), 1);
    walk("t4", o0);

    // Toggle flipped during reset and held through release: no event.
    I_RESET = 1'b0;
    ps2_key[10] = ~ps2_key[10];
    repeat (3) @(negedge clk_sys);
    I_RESET = 1'b1;
    f0 = n_frames;
    repeat (300) @(negedge clk_sys);
    chk("t5_frames", n_frames - f0, 0);
    chk("t5_clk", ps2_clk, 1);
    chk("t5_data", ps2_data, 1);
    chk("t5_busy", busy, 0);

    // Reset in the middle of the first of three queued bytes.
    send(1'b0, 1'b1, 8'h11);
    k = 0;
    while (bitn != 5 && k < 1000) begin @(negedge clk_sys); #1; k++; end
    chk("t6_reach_bit5", int'(k < 1000), 1);
    I_RESET = 1'b0;
    #1;
    chk("t6_async_clk", ps2_clk, 1);
    chk("t6_async_data", ps2_data, 1);
    exp_q.delete();
    repeat (3) @(negedge clk_sys);
    I_RESET = 1'b1;
    f0 = n_frames;
    repeat (400) @(negedge clk_sys);
    chk("t6_frames", n_frames - f0, 0);
    chk("t6_busy", busy, 0);
    chk("t6_clk", ps2_clk, 1);
    chk("t6_data", ps2_data, 1);

    // Twenty spaced makes walk the FIFO pointers through several wraps.
    o0 = ovf_cnt; f0 = n_frames;
    for (int i = 0; i < 20; i++) begin
      send(1'b1, 1'b0, 8'h40 + 8'(i));
      repeat (100) @(negedge clk_sys);
    end
    wait_idle(3000);
    chk("t7_frames", n_frames - f0, 20);
    chk("t7_ovf", ovf_cnt - o0, 0);
    chk("t7_sb", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
